// File: rtl/tag_ctrl.sv
// tag_ctrl: tag-array lookup controller for a 128-set, 16-byte-line cache.
// One request in flight; a miss writes back a dirty victim, then refills, then updates the tag.
module tag_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [6:0]  tag_addr,
  output logic        tag_en,
  output logic [54:0] tag_wdata,
  input  logic [54:0] tag_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [63:0] wb_addr,
  input  logic        wb_done,
  output logic        rf_valid,
  input  logic        rf_ready,
  output logic [63:0] rf_addr,
  input  logic        rf_done,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  // state   | meaning
  // IDLE    | ready; tag_addr follows req_addr
  // LOOKUP  | compare tag_rdata against latched tag
  // WB_REQ  | offer dirty victim for write-back
  // WB_WAIT | wait for write-back completion
  // RF_REQ  | offer line for refill
  // RF_WAIT | wait for refill completion
  // UPDATE  | write new tag entry
  // RESP    | one-cycle response pulse
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOOKUP  = 3'd1;
  localparam logic [2:0] WB_REQ  = 3'd2;
  localparam logic [2:0] WB_WAIT = 3'd3;
  localparam logic [2:0] RF_REQ  = 3'd4;
  localparam logic [2:0] RF_WAIT = 3'd5;
  localparam logic [2:0] UPDATE  = 3'd6;
  localparam logic [2:0] RESP    = 3'd7;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [52:0] r_tag;
  logic [52:0] r_old_tag;
  logic [6:0]  r_index;
  logic        r_wen;
  logic        r_hit;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        w_accept;
  logic        w_lookup;
  logic        w_valid;
  logic        w_dirty;
  logic        w_hit;
  logic        w_hit_wr;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_lookup = (r_state == LOOKUP);
  assign w_valid  = tag_rdata[54];
  assign w_dirty  = tag_rdata[53];
  assign w_hit    = w_valid && (tag_rdata[52:0] == r_tag);
  // Only a store to a clean line needs its dirty bit set.
  assign w_hit_wr = w_lookup && w_hit && r_wen && !w_dirty;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = LOOKUP;
      LOOKUP: begin
        if (w_hit)                   w_next = RESP;
        else if (w_valid && w_dirty) w_next = WB_REQ;
        else                         w_next = RF_REQ;
      end
      WB_REQ:  if (wb_ready) w_next = WB_WAIT;
      WB_WAIT: if (wb_done)  w_next = RF_REQ;
      RF_REQ:  if (rf_ready) w_next = RF_WAIT;
      RF_WAIT: if (rf_done)  w_next = UPDATE;
      UPDATE:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tag      <= '0;
      r_old_tag  <= '0;
      r_index    <= '0;
      r_wen      <= 1'b0;
      r_hit      <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_tag   <= req_addr[63:11];
        r_index <= req_addr[10:4];
        r_wen   <= req_wen;
      end
      if (w_lookup) begin
        r_hit <= w_hit;
        if (w_hit) begin
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end else begin
          r_miss_cnt <= r_miss_cnt + 32'd1;
          r_old_tag  <= tag_rdata[52:0];
        end
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_hit   = resp_valid && r_hit;
  assign tag_addr   = (r_state == IDLE) ? req_addr[10:4] : r_index;
  assign tag_en     = w_hit_wr || (r_state == UPDATE);
  assign tag_wdata  = (r_state == UPDATE) ? {1'b1, r_wen, r_tag} :
                      w_hit_wr            ? {2'b11, r_tag}       : 55'd0;
  assign wb_valid   = (r_state == WB_REQ);
  assign wb_addr    = {r_old_tag, r_index, 4'h0};
  assign rf_valid   = (r_state == RF_REQ);
  assign rf_addr    = {r_tag, r_index, 4'h0};
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;
endmodule

// File: tb/tb_tag_ctrl.sv
// tb_tag_ctrl: directed scenarios against a transaction-level model of tag_ctrl,
// with a tag-array and write-back/refill responder living in the bench.
module tb_tag_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic        resp_valid;
  logic        resp_hit;
  logic [6:0]  tag_addr;
  logic        tag_en;
  logic [54:0] tag_wdata;
  logic [54:0] tag_rdata;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [63:0] wb_addr;
  logic        wb_done = 1'b0;
  logic        rf_valid;
  logic        rf_ready = 1'b0;
  logic [63:0] rf_addr;
  logic        rf_done = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_chk = 0;
  int n_err = 0;

  tag_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .tag_addr(tag_addr), .tag_en(tag_en), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_done(wb_done),
    .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_addr(rf_addr), .rf_done(rf_done),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // tag array: combinational read, clocked write; pl_* lets the bench seed entries
  logic [54:0] mem [128];
  logic        pl_en = 1'b0;
  logic [6:0]  pl_idx = '0;
  logic [54:0] pl_val = '0;
  assign tag_rdata = mem[tag_addr];
  always @(posedge clk) begin
    if (pl_en)       mem[pl_idx]   <= pl_val;
    else if (tag_en) mem[tag_addr] <= tag_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_req_ready"},  {63'd0, req_ready},  64'd1);
    chk({pfx, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
    chk({pfx, "_resp_hit"},   {63'd0, resp_hit},   64'd0);
    chk({pfx, "_tag_en"},     {63'd0, tag_en},     64'd0);
    chk({pfx, "_wb_valid"},   {63'd0, wb_valid},   64'd0);
    chk({pfx, "_rf_valid"},   {63'd0, rf_valid},   64'd0);
    chk({pfx, "_tag_wdata"},  {9'd0, tag_wdata},   64'd0);
    chk({pfx, "_wb_addr"},    wb_addr,             64'd0);
    chk({pfx, "_rf_addr"},    rf_addr,             64'd0);
    chk({pfx, "_hit_cnt"},    {32'd0, hit_cnt},    64'd0);
    chk({pfx, "_miss_cnt"},   {32'd0, miss_cnt},   64'd0);
  endtask

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit          m_busy = 0;
  int          m_cyc;
  logic [6:0]  m_idx;
  logic [52:0] m_tag;
  logic        m_wen;
  bit          m_hit, m_wb_need, m_wr_need, m_wr_seen;
  bit          m_wb_hs, m_wb_fin, m_rf_hs, m_rf_fin;
  logic [63:0] m_wb_addr, m_rf_addr;
  logic [54:0] m_wr_data;
  logic [31:0] m_hit_cnt = '0;
  logic [31:0] m_miss_cnt = '0;

  always @(negedge clk) begin : compare
    logic [54:0] e;
    bit wb_hs_prev, rf_hs_prev;
    if (rst) begin
      check_reset("rst_hold");
      m_busy     = 0;
      m_hit_cnt  = '0;
      m_miss_cnt = '0;
    end else if (m_busy) begin
      m_cyc++;
      wb_hs_prev = m_wb_hs;
      rf_hs_prev = m_rf_hs;
      chk("ready_busy", {63'd0, req_ready}, 64'd0);
      chk("tag_addr_busy", {57'd0, tag_addr}, {57'd0, m_idx});
      if (tag_en) begin
        chk("tag_en_allowed",
            {63'd0, m_wr_need && !m_wr_seen && (m_hit ? (m_cyc == 1) : m_rf_fin)}, 64'd1);
        chk("tag_wdata", {9'd0, tag_wdata}, {9'd0, m_wr_data});
        m_wr_seen = 1;
      end
      if (wb_valid) begin
        chk("wb_allowed", {63'd0, m_wb_need && !m_wb_hs}, 64'd1);
        chk("wb_addr", wb_addr, m_wb_addr);
        if (wb_ready) m_wb_hs = 1;
      end
      if (rf_valid) begin
        chk("rf_allowed", {63'd0, !m_hit && !m_rf_hs && (!m_wb_need || m_wb_fin)}, 64'd1);
        chk("rf_addr", rf_addr, m_rf_addr);
        if (rf_ready) m_rf_hs = 1;
      end
      if (resp_valid) begin
        chk("resp_hit", {63'd0, resp_hit}, {63'd0, m_hit});
        if (m_hit) chk("hit_latency", 64'(m_cyc), 64'd2);
        chk("tag_write_done", {63'd0, m_wr_seen}, {63'd0, m_wr_need});
        chk("refill_done", {63'd0, m_rf_fin}, {63'd0, !m_hit});
        chk("hit_cnt_resp", {32'd0, hit_cnt}, {32'd0, m_hit_cnt});
        chk("miss_cnt_resp", {32'd0, miss_cnt}, {32'd0, m_miss_cnt});
        m_busy = 0;
      end
      // completions only count once their request was taken
      if (wb_done && wb_hs_prev) m_wb_fin = 1;
      if (rf_done && rf_hs_prev) m_rf_fin = 1;
    end else begin
      chk("ready_idle", {63'd0, req_ready}, 64'd1);
      chk("tag_addr_idle", {57'd0, tag_addr}, {57'd0, req_addr[10:4]});
      chk("tag_en_idle", {63'd0, tag_en}, 64'd0);
      chk("wb_valid_idle", {63'd0, wb_valid}, 64'd0);
      chk("rf_valid_idle", {63'd0, rf_valid}, 64'd0);
      chk("resp_valid_idle", {63'd0, resp_valid}, 64'd0);
      chk("hit_cnt_idle", {32'd0, hit_cnt}, {32'd0, m_hit_cnt});
      chk("miss_cnt_idle", {32'd0, miss_cnt}, {32'd0, m_miss_cnt});
      if (req_valid) begin
        m_idx     = req_addr[10:4];
        m_tag     = req_addr[63:11];
        m_wen     = req_wen;
        e         = mem[m_idx];
        m_hit     = e[54] && (e[52:0] == m_tag);
        m_wb_need = !m_hit && e[54] && e[53];
        m_wb_addr = {e[52:0], m_idx, 4'h0};
        m_rf_addr = {m_tag, m_idx, 4'h0};
        m_wr_need = !m_hit || (m_wen && !e[53]);
        m_wr_data = m_hit ? {2'b11, m_tag} : {1'b1, m_wen, m_tag};
        if (m_hit) m_hit_cnt++;
        else       m_miss_cnt++;
        m_wr_seen = 0; m_wb_hs = 0; m_wb_fin = 0; m_rf_hs = 0; m_rf_fin = 0;
        m_cyc  = 0;
        m_busy = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [63:0] mk(input logic [52:0] t, input logic [6:0] i, input logic [3:0] o);
    return {t, i, o};
  endfunction

  task automatic preload(input logic [6:0] idx, input logic [54:0] val);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one request and plays write-back/refill responder until resp_valid.
  task automatic run_txn(input logic [63:0] addr, input logic wen, input int wb_hold,
                         input bit rst_rfwait);
    int wb_cnt = 0;
    int wb_dly = 0;
    int rf_dly = 0;
    bit wb_hs = 0;
    bit rf_hs = 0;
    bit done = 0;
    @(posedge clk); #1;
    req_addr = addr; req_wen = wen; req_valid = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      wb_ready = 1'b0; rf_ready = 1'b0; wb_done = 1'b0; rf_done = 1'b0;
      if (resp_valid) begin
        done = 1;
      end else begin
        if (wb_hs && wb_dly > 0) begin
          wb_dly--;
          if (wb_dly == 0) wb_done = 1'b1;
        end
        if (rf_hs && rf_dly > 0) begin
          if (rst_rfwait) begin
            rst = 1'b1;
            #1;
            check_reset("rst_rfwait");
            done = 1;
          end else begin
            rf_dly--;
            if (rf_dly == 0) rf_done = 1'b1;
          end
        end
        if (wb_valid && !wb_hs) begin
          if (wb_cnt >= wb_hold) begin
            wb_ready = 1'b1; wb_hs = 1; wb_dly = 2;
          end else begin
            wb_cnt++;
            // completions arriving before their WAIT state must be ignored
            if (wb_cnt == 1) begin wb_done = 1'b1; rf_done = 1'b1; end
          end
        end
        if (rf_valid && !rf_hs) begin
          rf_ready = 1'b1; rf_hs = 1; rf_dly = 2;
        end
      end
    end
    if (!done) chk("txn_timeout", 64'd0, 64'd1);
  endtask

  localparam logic [52:0] T = 53'h1_2345_6789_ABCD;
  localparam logic [52:0] A = 53'h0_DEAD_BEEF_0001;
  localparam logic [52:0] B = 53'h1_0F0F_0F0F_0F0F;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // clean read hit, write hit on clean line, write hit on dirty line
    preload(7'd5, {2'b10, T});
    run_txn(mk(T, 7'd5, 4'h8), 1'b0, 0, 0);
    chk("lit_hit_cnt1", {32'd0, hit_cnt}, 64'd1);
    chk("lit_mem5_clean", {9'd0, mem[5]}, {9'd0, 2'b10, T});
    run_txn(mk(T, 7'd5, 4'h0), 1'b1, 0, 0);
    chk("lit_mem5_dirty", {9'd0, mem[5]}, {9'd0, 2'b11, T});
    run_txn(mk(T, 7'd5, 4'h4), 1'b1, 0, 0);
    chk("lit_hit_cnt3", {32'd0, hit_cnt}, 64'd3);

    // clean miss, then dirty miss with wb_ready held off
    preload(7'd3, {2'b10, A});
    run_txn(mk(B, 7'd3, 4'h0), 1'b0, 0, 0);
    chk("lit_mem3_clean_miss", {9'd0, mem[3]}, {9'd0, 2'b10, B});
    chk("lit_miss_cnt1", {32'd0, miss_cnt}, 64'd1);
    preload(7'd3, {2'b11, A});
    run_txn(mk(B, 7'd3, 4'h0), 1'b1, 4, 0);
    chk("lit_mem3_dirty_miss", {9'd0, mem[3]}, {9'd0, 2'b11, B});
    chk("lit_miss_cnt2", {32'd0, miss_cnt}, 64'd2);

    // matching tag but invalid entry is a miss and needs no write-back
    preload(7'd9, {2'b01, T});
    run_txn(mk(T, 7'd9, 4'h0), 1'b0, 0, 0);
    chk("lit_mem9", {9'd0, mem[9]}, {9'd0, 2'b10, T});

    // reset during refill wait, stray completions, then a normal request
    preload(7'd20, {2'b10, A});
    run_txn(mk(B, 7'd20, 4'h0), 1'b0, 0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rf_done = 1'b1; wb_done = 1'b1;
    @(posedge clk); #1;
    rf_done = 1'b0; wb_done = 1'b0;
    chk("lit_mem20_kept", {9'd0, mem[20]}, {9'd0, 2'b10, A});
    run_txn(mk(A, 7'd20, 4'h0), 1'b0, 0, 0);
    chk("lit_hit_after_rst", {32'd0, hit_cnt}, 64'd1);

    // miss counter wrap
    preload(7'd40, 55'd0);
    @(posedge clk); #1;
    force dut.r_miss_cnt = 32'hFFFF_FFFF;
    m_miss_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_miss_cnt;
    run_txn(mk(A, 7'd40, 4'h0), 1'b0, 0, 0);
    chk("lit_miss_wrap", {32'd0, miss_cnt}, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
